// File: rtl/temp_pkg.sv
// Shared types and widths for the temperature scan controller and its divider.
package temp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_DIVIDE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int SUM_W        = 16;
    localparam int CNT_W        = 8;
    localparam int TEMP_MIN_DEF = 19;
    localparam int TEMP_MAX_DEF = 26;

endpackage

// File: rtl/seq_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, the first bit is resolved on
// the start edge so quotient/remainder are valid while done_o is high, 16 cycles after start.
module seq_divider
    import temp_pkg::*;
#(
    parameter int W = SUM_W
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] quotient_o,
    output logic [W-1:0] remainder_o,
    output logic         done_o
);

    localparam int CW = $clog2(W) + 1;

    logic [W-1:0]  rem_q, rem_d;
    logic [W-1:0]  quo_q, quo_d;
    logic [W-1:0]  dvs_q, dvs_d;
    logic [CW-1:0] iter_q, iter_d;
    logic          run_q, run_d;
    logic          done_q, done_d;

    // quo doubles as the dividend shift register: its MSB feeds the partial remainder.
    function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                                input logic [W-1:0] quo,
                                                input logic [W-1:0] dvs);
        logic [W:0] trial;
        trial = {rem, quo[W-1]};
        if (trial >= {1'b0, dvs}) begin
            return {trial[W-1:0] - dvs, quo[W-2:0], 1'b1};
        end
        return {trial[W-1:0], quo[W-2:0], 1'b0};
    endfunction

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        iter_d = iter_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start_i) begin
            {rem_d, quo_d} = div_step('0, dividend_i, divisor_i);
            dvs_d          = divisor_i;
            iter_d         = CW'(W - 1);
            run_d          = 1'b1;
        end else if (run_q) begin
            {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
            iter_d         = iter_q - CW'(1);
            if (iter_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            iter_q <= iter_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign quotient_o  = quo_q;
    assign remainder_o = rem_q;
    assign done_o      = done_q;

endmodule

// File: rtl/temp_scan_ctrl.sv
// Scans a snapshot of the enabled temperature sensors, averages them with round-half-up
// via the sequential divider, and flags averages outside [TEMP_MIN, TEMP_MAX].
module temp_scan_ctrl
    import temp_pkg::*;
#(
    parameter int NR_OF_SENSORS = 5,
    parameter int TEMP_MIN      = TEMP_MIN_DEF,
    parameter int TEMP_MAX      = TEMP_MAX_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic [NR_OF_SENSORS*8-1:0] sensors_data_i,
    input  logic [NR_OF_SENSORS-1:0]   sensors_en_i,
    output logic                       busy_o,
    output logic                       done_o,
    output logic [7:0]                 avg_o,
    output logic [7:0]                 nr_active_o,
    output logic                       alert_o
);

    localparam int              DW       = NR_OF_SENSORS * 8;
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NR_OF_SENSORS - 1);
    localparam logic [7:0]      TMIN     = 8'(TEMP_MIN);
    localparam logic [7:0]      TMAX     = 8'(TEMP_MAX);

    state_e                 state_q, state_d;
    logic [DW-1:0]          data_snap_q, data_snap_d;
    logic [NR_OF_SENSORS-1:0] en_snap_q, en_snap_d;
    logic [SUM_W-1:0]       sum_q, sum_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [7:0]             avg_q, avg_d;
    logic [7:0]             nr_q, nr_d;
    logic                   alert_q, alert_d;

    logic [7:0]             cur_byte;
    logic                   cur_en;
    logic                   div_start;
    logic [SUM_W-1:0]       div_quo, div_rem;
    logic                   div_done;

    function automatic logic [7:0] round_avg(input logic [SUM_W-1:0] q,
                                             input logic [SUM_W-1:0] r,
                                             input logic [CNT_W-1:0] cnt);
        logic [SUM_W:0] r2;
        logic [SUM_W:0] rounded;
        r2      = {r, 1'b0};
        rounded = {1'b0, q} + {{SUM_W{1'b0}}, (r2 >= {{(SUM_W+1-CNT_W){1'b0}}, cnt})};
        return (rounded > (SUM_W+1)'(255)) ? 8'hFF : rounded[7:0];
    endfunction

    function automatic logic out_of_range(input logic [7:0] avg);
        return (avg < TMIN) || (avg > TMAX);
    endfunction

    always_comb begin
        cur_byte = '0;
        cur_en   = 1'b0;
        for (int k = 0; k < NR_OF_SENSORS; k++) begin
            if (idx_q == CNT_W'(k)) begin
                cur_byte = data_snap_q[8*k +: 8];
                cur_en   = en_snap_q[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        data_snap_d = data_snap_q;
        en_snap_d   = en_snap_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        avg_d       = avg_q;
        nr_d        = nr_q;
        alert_d     = alert_q;
        div_start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    data_snap_d = sensors_data_i;
                    en_snap_d   = sensors_en_i;
                    sum_d       = '0;
                    cnt_d       = '0;
                    idx_d       = '0;
                    state_d     = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (cur_en) begin
                    sum_d = sum_q + {{(SUM_W-8){1'b0}}, cur_byte};
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // The divider is launched with the just-updated sum/count so no cycle is lost.
                if (idx_q == IDX_LAST) begin
                    if (cnt_d != '0) begin
                        div_start = 1'b1;
                        state_d   = ST_DIVIDE;
                    end else begin
                        avg_d   = '0;
                        nr_d    = '0;
                        alert_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            ST_DIVIDE: begin
                if (div_done) begin
                    avg_d   = round_avg(div_quo, div_rem, cnt_q);
                    nr_d    = cnt_q;
                    alert_d = out_of_range(round_avg(div_quo, div_rem, cnt_q));
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            data_snap_q <= '0;
            en_snap_q   <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            avg_q       <= '0;
            nr_q        <= '0;
            alert_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_snap_q <= data_snap_d;
            en_snap_q   <= en_snap_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            avg_q       <= avg_d;
            nr_q        <= nr_d;
            alert_q     <= alert_d;
        end
    end

    seq_divider #(
        .W(SUM_W)
    ) u_div (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (div_start),
        .dividend_i  (sum_d),
        .divisor_i   ({{(SUM_W-CNT_W){1'b0}}, cnt_d}),
        .quotient_o  (div_quo),
        .remainder_o (div_rem),
        .done_o      (div_done)
    );

    assign busy_o      = (state_q != ST_IDLE);
    assign done_o      = (state_q == ST_DONE);
    assign avg_o       = avg_q;
    assign nr_active_o = nr_q;
    assign alert_o     = alert_q;

endmodule

// File: tb/tb_temp_scan_ctrl.sv
// Bench for temp_scan_ctrl (5 sensors): directed vector table, multi-cycle corner
// sequences and randomized runs against an arithmetic reference model.
module tb_temp_scan_ctrl;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start_i;
    logic [N*8-1:0] sensors_data;
    logic [N-1:0]   sensors_en;
    logic           busy_o;
    logic           done_o;
    logic [7:0]     avg_o;
    logic [7:0]     nr_active_o;
    logic           alert_o;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [N*8-1:0] data;
        logic [N-1:0]   en;
        int             avg;
        int             nr;
        int             alert;
        int             lat;
    } vec_t;

    vec_t vecs[12];

    temp_scan_ctrl #(
        .NR_OF_SENSORS(N),
        .TEMP_MIN(19),
        .TEMP_MAX(26)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .start_i        (start_i),
        .sensors_data_i (sensors_data),
        .sensors_en_i   (sensors_en),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .avg_o          (avg_o),
        .nr_active_o    (nr_active_o),
        .alert_o        (alert_o)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Reference: average rounded half-up as floor((2*sum + n) / (2*n)), saturated.
    function automatic void model(input logic [N*8-1:0] d, input logic [N-1:0] e,
                                  output int avg, output int nr, output int alert,
                                  output int lat);
        int sum = 0;
        int cnt = 0;
        for (int k = 0; k < N; k++) begin
            if (e[k]) begin
                sum += int'(d[8*k +: 8]);
                cnt++;
            end
        end
        if (cnt == 0) begin
            avg = 0; nr = 0; alert = 1; lat = N + 1;
        end else begin
            avg   = (2 * sum + cnt) / (2 * cnt);
            if (avg > 255) avg = 255;
            nr    = cnt;
            alert = (avg < 19 || avg > 26) ? 1 : 0;
            lat   = N + 17;
        end
    endfunction

    // Entered at the falling edge inside T1; returns the cycle index in which done_o is seen.
    task automatic wait_done(input bit scramble, output int t);
        logic [63:0] r64;
        t = 1;
        while (!done_o && t <= 60) begin
            if (scramble) begin
                r64          = {$urandom(), $urandom()};
                sensors_data = r64[N*8-1:0];
                sensors_en   = N'($urandom());
                start_i      = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            t++;
        end
        if (!done_o) t = -1;
    endtask

    task automatic run_one(input logic [N*8-1:0] d, input logic [N-1:0] e,
                           input int eavg, input int enr, input int ealert, input int elat,
                           input string tag);
        int t;
        int held;
        @(negedge clk);
        sensors_data = d;
        sensors_en   = e;
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, "_busy_t1"}, int'(busy_o), 1);
        wait_done(1'b1, t);
        start_i = 1'b0;
        check({tag, "_latency"}, t, elat);
        check({tag, "_avg"}, int'(avg_o), eavg);
        check({tag, "_nr"}, int'(nr_active_o), enr);
        check({tag, "_alert"}, int'(alert_o), ealert);
        held = int'(avg_o);
        @(negedge clk);
        check({tag, "_done_pulse"}, int'(done_o), 0);
        check({tag, "_idle_after"}, int'(busy_o), 0);
        check({tag, "_avg_held"}, int'(avg_o), held);
    endtask

    task automatic abort_at(input int tcyc, input string tag);
        bit saw_done;
        bit saw_busy;
        @(negedge clk);
        sensors_data = {N{8'd40}};
        sensors_en   = '1;
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (tcyc - 1) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_busy"}, int'(busy_o), 0);
        check({tag, "_done"}, int'(done_o), 0);
        check({tag, "_avg"}, int'(avg_o), 0);
        check({tag, "_nr"}, int'(nr_active_o), 0);
        check({tag, "_alert"}, int'(alert_o), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        saw_busy = 1'b0;
        repeat (30) begin
            @(negedge clk);
            saw_done |= done_o;
            saw_busy |= busy_o;
        end
        check({tag, "_no_done_after"}, int'(saw_done), 0);
        check({tag, "_no_restart"}, int'(saw_busy), 0);
    endtask

    initial begin
        int t;
        int ea, en_, eal, el;
        logic [N*8-1:0] rd;
        logic [N-1:0]   re;
        bit             changed;
        int             held;

        vecs[0]  = '{{8'd30, 8'd0, 8'd24, 8'd22, 8'd20}, 5'b10111, 24, 4, 0, 22};
        vecs[1]  = '{{8'd0, 8'd0, 8'd21, 8'd21, 8'd20}, 5'b00111, 21, 3, 0, 22};
        vecs[2]  = '{{N{8'd50}}, 5'b00000, 0, 0, 1, 6};
        vecs[3]  = '{{N{8'd40}}, 5'b11111, 40, 5, 1, 22};
        vecs[4]  = '{{N{8'd19}}, 5'b11111, 19, 5, 0, 22};
        vecs[5]  = '{{N{8'd26}}, 5'b11111, 26, 5, 0, 22};
        vecs[6]  = '{{N{8'd27}}, 5'b11111, 27, 5, 1, 22};
        vecs[7]  = '{{N{8'd18}}, 5'b11111, 18, 5, 1, 22};
        vecs[8]  = '{{N{8'd255}}, 5'b11111, 255, 5, 1, 22};
        vecs[9]  = '{{8'd99, 8'd99, 8'd99, 8'd99, 8'd0}, 5'b00001, 0, 1, 1, 22};
        vecs[10] = '{{8'd0, 8'd0, 8'd0, 8'd21, 8'd20}, 5'b00011, 21, 2, 0, 22};
        vecs[11] = '{{8'd0, 8'd0, 8'd21, 8'd20, 8'd20}, 5'b00111, 20, 3, 0, 22};

        rst_n        = 1'b0;
        start_i      = 1'b0;
        sensors_data = '0;
        sensors_en   = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy_o), 0);
        check("reset_done", int'(done_o), 0);
        check("reset_avg", int'(avg_o), 0);
        check("reset_nr", int'(nr_active_o), 0);
        check("reset_alert", int'(alert_o), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_without_start", int'(busy_o), 0);

        for (int i = 0; i < 12; i++) begin
            run_one(vecs[i].data, vecs[i].en, vecs[i].avg, vecs[i].nr, vecs[i].alert,
                    vecs[i].lat, $sformatf("vec%0d", i));
        end

        changed = 1'b0;
        held    = int'(avg_o);
        repeat (6) begin
            @(negedge clk);
            sensors_data = {$urandom(), 8'($urandom())};
            sensors_en   = N'($urandom());
            changed |= (int'(avg_o) != held) || done_o;
        end
        check("outputs_hold_idle", int'(changed), 0);

        @(negedge clk);
        sensors_data = {8'd30, 8'd0, 8'd24, 8'd22, 8'd20};
        sensors_en   = 5'b10111;
        start_i      = 1'b1;
        @(negedge clk);
        wait_done(1'b0, t);
        check("retrig_first_latency", t, 22);
        check("retrig_first_avg", int'(avg_o), 24);
        @(negedge clk);
        check("retrig_idle_cycle", int'(busy_o), 0);
        @(negedge clk);
        check("retrig_restarted", int'(busy_o), 1);
        wait_done(1'b0, t);
        start_i = 1'b0;
        check("retrig_second_latency", t, 22);
        check("retrig_second_avg", int'(avg_o), 24);
        @(negedge clk);
        check("retrig_stops", int'(busy_o), 0);

        run_one({N{8'd40}}, 5'b11111, 40, 5, 1, 22, "pre_abort_divide");
        abort_at(10, "abort_divide");
        run_one({N{8'd40}}, 5'b11111, 40, 5, 1, 22, "pre_abort_scan");
        abort_at(3, "abort_scan");
        run_one(vecs[0].data, vecs[0].en, 24, 4, 0, 22, "after_abort");

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < N; k++) begin
                rd[8*k +: 8] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                            : 8'($urandom_range(14, 31));
            end
            re = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom_range(0, 31));
            model(rd, re, ea, en_, eal, el);
            run_one(rd, re, ea, en_, eal, el, $sformatf("rand%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
